// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between an on-chip producer and the uart_tx_fifo input FIFO.
// The producer side is the master; the transmitter is the slave.
interface uart_tx_fifo_if;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;

   modport master (output data_in, output valid_in, input ready_out);
   modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular-buffer FIFO over a valid/ready handshake.
// Frames are sent back to back while bytes are queued; tx idles high.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 10,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic          clk,
   input  logic          rst,
   uart_tx_fifo_if.slave in_if,
   output logic          tx,
   output logic          busy_out
);
   localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e           state_q, state_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [CntW-1:0]  count_q, count_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             push, pop, baud_done, fifo_empty;

   assign fifo_empty      = (count_q == '0);
   assign in_if.ready_out = (count_q < CntFull);
   assign push            = in_if.valid_in && in_if.ready_out;
   assign baud_done       = (baud_q == BaudLast);
   assign tx              = tx_q;
   assign busy_out        = (state_q != StIdle) || !fifo_empty;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rptr_q];
               tx_d    = 1'b0;
               baud_d  = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            baud_d = baud_q + 1'b1;
            if (baud_done) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = StData;
            end
         end
         StData: begin
            baud_d = baud_q + 1'b1;
            if (baud_done) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  // Shift register keeps the bit being driven in position 0.
                  bit_d   = bit_q + 1'b1;
                  shift_d = {1'b0, shift_q[7:1]};
                  tx_d    = shift_q[1];
               end
            end
         end
         StStop: begin
            baud_d = baud_q + 1'b1;
            if (baud_done) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem_q[rptr_q];
                  tx_d    = 1'b0;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wptr_q] <= in_if.data_in;
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-position model checked every cycle, a serial decoder
// standing in for the receiver, and directed scenarios with hand-computed timings.
module tb_uart_tx_fifo;
   localparam int CPB   = 10;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx, busy, tx2, busy2;

   uart_tx_fifo_if ifc ();
   uart_tx_fifo_if ifc2 ();

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_if(ifc), .tx(tx), .busy_out(busy)
   );

   uart_tx_fifo #(.CLKS_PER_BIT(2), .FIFO_DEPTH(DEPTH)) dut2 (
      .clk(clk), .rst(rst), .in_if(ifc2), .tx(tx2), .busy_out(busy2)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Model: bytes waiting, plus the active frame and how many cycles into it we are.
   logic [7:0] m_q [$];
   logic [7:0] m_cur;
   int         m_t;
   bit         m_act, m_on, m_push, m_pop;
   int         m_bit;
   logic       e_tx;

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_q.delete();
         m_act = 0;
         m_t   = 0;
         m_on  = 1;
      end else if (m_on) begin
         m_push = ifc.valid_in && (m_q.size() < DEPTH);
         m_pop  = (m_q.size() != 0) && (!m_act || m_t == 10 * CPB - 1);
         if (m_pop) begin
            m_cur = m_q.pop_front();
            m_act = 1;
            m_t   = 0;
         end else if (m_act) begin
            m_t++;
            if (m_t == 10 * CPB) m_act = 0;
         end
         if (m_push) m_q.push_back(ifc.data_in);
      end
      #1;
      if (m_on) begin
         m_bit = m_t / CPB;
         if (!m_act)          e_tx = 1'b1;
         else if (m_bit == 0) e_tx = 1'b0;
         else if (m_bit == 9) e_tx = 1'b1;
         else                 e_tx = m_cur[m_bit-1];
         check("model tx", tx, e_tx);
         check("model ready_out", ifc.ready_out, m_q.size() < DEPTH);
         check("model busy_out", busy, m_act || m_q.size() != 0);
      end
   end

   // Serial decoder on tx: samples mid-bit, like a receiver in loopback.
   logic [7:0] rx_q [$];
   logic [7:0] d_byte;
   int         d_cnt = -1;

   initial forever begin
      @(posedge clk);
      #1;
      if (rst) begin
         d_cnt = -1;
      end else if (d_cnt < 0) begin
         if (tx === 1'b0) d_cnt = 0;
      end else begin
         d_cnt++;
         if (d_cnt % CPB == CPB / 2 && d_cnt / CPB >= 1 && d_cnt / CPB <= 8)
            d_byte[d_cnt/CPB-1] = tx;
         if (d_cnt == 9 * CPB + CPB / 2) begin
            rx_q.push_back(d_byte);
            d_cnt = -1;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push_byte(input logic [7:0] d, output int at);
      int n;
      ifc.data_in  = d;
      ifc.valid_in = 1'b1;
      n = 0;
      while (!ifc.ready_out && n < 2000) begin
         step(1);
         n++;
      end
      check("ready before push", ifc.ready_out, 1'b1);
      step(1);
      at = cyc;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         step(1);
         n++;
      end
      check("drain busy_out", busy, 1'b0);
   endtask

   initial begin
      int         acc [6];
      int         k, bad, at;
      logic [9:0] frame;
      logic [7:0] exp_b [6];

      ifc.data_in   = '0;
      ifc.valid_in  = 1'b0;
      ifc2.data_in  = '0;
      ifc2.valid_in = 1'b0;
      step(3);
      check("reset tx", tx, 1'b1);
      check("reset ready_out", ifc.ready_out, 1'b1);
      check("reset busy_out", busy, 1'b0);
      check("reset tx2", tx2, 1'b1);
      rst = 1'b0;

      // Idle: nothing to send for 1000 cycles.
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         step(1);
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("idle disturbances", bad, 0);

      // Single byte 0xA5: sample the middle of every bit.
      rx_q.delete();
      frame = 10'b1_10100101_0;
      push_byte(8'hA5, k);
      ifc.valid_in = 1'b0;
      step(6);
      check("A5 start bit", tx, frame[0]);
      for (int b = 1; b < 10; b++) begin
         step(10);
         check("A5 frame bit", tx, frame[b]);
      end
      check("A5 busy in stop", busy, 1'b1);
      step(5);
      check("A5 busy after stop", busy, 1'b0);
      check("A5 tx after stop", tx, 1'b1);
      check("A5 decoded count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("A5 decoded byte", rx_q[0], 8'hA5);

      // Burst 0x00..0x05 with valid held.
      rx_q.delete();
      for (int i = 0; i < 6; i++) push_byte(8'(i), acc[i]);
      ifc.valid_in = 1'b0;
      check("burst byte4 accept", acc[4] - acc[0], 4);
      check("burst byte5 accept", acc[5] - acc[0], 102);
      while (cyc < acc[0] + 600) step(1);
      check("burst busy at end", busy, 1'b1);
      step(1);
      check("burst busy after 600", busy, 1'b0);
      check("burst decoded count", rx_q.size(), 6);
      for (int i = 0; i < 6 && i < rx_q.size(); i++) check("burst order", rx_q[i], i);

      // Reset during bit 3 of a 0xFF frame with two bytes queued.
      rx_q.delete();
      push_byte(8'hFF, k);
      push_byte(8'h11, at);
      push_byte(8'h22, at);
      ifc.valid_in = 1'b0;
      while (cyc < k + 44) step(1);
      rst = 1'b1;
      step(1);
      check("midreset tx", tx, 1'b1);
      check("midreset ready_out", ifc.ready_out, 1'b1);
      check("midreset busy_out", busy, 1'b0);
      rst = 1'b0;
      step(300);
      check("midreset no frames", rx_q.size(), 0);
      check("midreset tx idle", tx, 1'b1);

      // Push coinciding with the STOP->START pop while two bytes are queued.
      rx_q.delete();
      exp_b = '{8'hC3, 8'h81, 8'h7E, 8'h42, 8'h99, 8'h0F};
      push_byte(exp_b[0], k);
      push_byte(exp_b[1], at);
      push_byte(exp_b[2], at);
      ifc.valid_in = 1'b0;
      while (cyc < k + 100) step(1);
      push_byte(exp_b[3], at);
      check("pushpop accept cycle", at - k, 101);
      push_byte(exp_b[4], at);
      check("pushpop ready at 3", ifc.ready_out, 1'b1);
      push_byte(exp_b[5], at);
      ifc.valid_in = 1'b0;
      check("pushpop ready at 4", ifc.ready_out, 1'b0);
      wait_idle(800);
      check("pushpop decoded count", rx_q.size(), 6);
      for (int i = 0; i < 6 && i < rx_q.size(); i++) check("pushpop order", rx_q[i], exp_b[i]);

      // Two clocks per bit, byte 0x3C.
      frame = 10'b1_00111100_0;
      ifc2.data_in  = 8'h3C;
      ifc2.valid_in = 1'b1;
      step(1);
      ifc2.valid_in = 1'b0;
      for (int j = 1; j <= 20; j++) begin
         step(1);
         check("cpb2 tx", tx2, frame[(j-1)/2]);
      end
      check("cpb2 busy in stop", busy2, 1'b1);
      step(1);
      check("cpb2 busy after", busy2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
